lock_controller: RTL and testbench

- Top-level sequencing FSM for the combination-lock system.
- Collects digit entry from the switches, compares it against the stored password, and drives the shared seconds timer (start/abort/duration).
- Consumes the timer's finished pulse and publishes the 2-bit system state used by the timer and the display logic.
- Also owns password change (editing), the failed-attempt counter, and alarm latch/clear.

---
 rtl/lock_controller.sv | 172 +++++++++++++++++
 tb/tb_lock_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lock_controller.sv
// lock_controller: top-level sequencing FSM for the combination lock.
// Collects digit entry, checks it against the stored password, drives the
// shared seconds timer, counts failed attempts and latches/clears the alarm.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_switches[3:0]     digit value, sampled when i_load pulses
//   i_load              append digit pulse
//   i_ok                submit / leave unlocked pulse
//   i_admin_button      enter editing from unlocked, clear alarm
//   i_timer_finished    timer expiry pulse
//   o_state[1:0]        00 waiting, 01 editing, 10 unlocked, 11 alarming
//   o_timer_start       timer load-and-run pulse
//   o_timer_abort       timer stop-and-clear pulse
//   o_timer_secs[7:0]   requested duration, held until the next start
//   o_digit_count[2:0]  digits held in the entry buffer
//   o_fail_count[1:0]   consecutive failed attempts
//   o_err               rejected submission pulse
module lock_controller #(
    parameter int PW_DIGITS = 4,
    parameter int MAX_TRIES = 3,
    parameter int UNLOCK_SECS = 20,
    parameter int EDIT_SECS = 10,
    parameter logic [4*PW_DIGITS-1:0] DEFAULT_PW = 16'h1234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_switches,
    input  logic       i_load,
    input  logic       i_ok,
    input  logic       i_admin_button,
    input  logic       i_timer_finished,
    output logic [1:0] o_state,
    output logic       o_timer_start,
    output logic       o_timer_abort,
    output logic [7:0] o_timer_secs,
    output logic [2:0] o_digit_count,
    output logic [1:0] o_fail_count,
    output logic       o_err
);
    localparam int EW = 4 * PW_DIGITS;
    localparam logic [2:0] FULL = 3'(PW_DIGITS);
    localparam logic [1:0] MAX_FC = 2'(MAX_TRIES);
    localparam logic [7:0] UNLOCK_S = 8'(UNLOCK_SECS);
    localparam logic [7:0] EDIT_S = 8'(EDIT_SECS);

    typedef enum logic [1:0] {
        S_WAIT   = 2'b00,
        S_EDIT   = 2'b01,
        S_UNLOCK = 2'b10,
        S_ALARM  = 2'b11
    } state_t;

    state_t         r_state, w_state;
    logic [EW-1:0]  r_entry, w_entry, r_pw, w_pw;
    logic [2:0]     r_dc, w_dc;
    logic [1:0]     r_fc, w_fc;
    logic [7:0]     r_secs, w_secs;
    logic           r_start, w_start, r_abort, w_abort, r_err, w_err;
    logic           w_full;
    logic [1:0]     w_fc_inc;

    assign w_full = (r_dc == FULL);
    assign w_fc_inc = r_fc + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_entry <= '0;
            r_pw    <= DEFAULT_PW;
            r_dc    <= '0;
            r_fc    <= '0;
            r_secs  <= '0;
            r_start <= 1'b0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_entry <= w_entry;
            r_pw    <= w_pw;
            r_dc    <= w_dc;
            r_fc    <= w_fc;
            r_secs  <= w_secs;
            r_start <= w_start;
            r_abort <= w_abort;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        w_entry = r_entry;
        w_pw    = r_pw;
        w_dc    = r_dc;
        w_fc    = r_fc;
        w_secs  = r_secs;
        w_start = 1'b0;
        w_abort = 1'b0;
        w_err   = 1'b0;
        // ok takes precedence over a coincident load; a full buffer drops loads
        if ((r_state == S_WAIT || r_state == S_EDIT) && i_load && !i_ok && !w_full) begin
            w_entry = {r_entry[EW-5:0], i_switches};
            w_dc    = r_dc + 3'd1;
        end
        case (r_state)
            S_WAIT: begin
                if (i_ok) begin
                    w_entry = '0;
                    w_dc    = '0;
                    if (w_full && r_entry == r_pw) begin
                        w_state = S_UNLOCK;
                        w_fc    = '0;
                        w_start = 1'b1;
                        w_secs  = UNLOCK_S;
                    end else begin
                        w_err = 1'b1;
                        w_fc  = w_fc_inc;
                        if (w_fc_inc == MAX_FC) w_state = S_ALARM;
                    end
                end
            end
            S_UNLOCK: begin
                if (i_timer_finished) begin
                    w_state = S_WAIT;
                end else if (i_ok) begin
                    w_state = S_WAIT;
                    w_abort = 1'b1;
                end else if (i_admin_button) begin
                    // a fresh start reloads the timer, so no abort is issued
                    w_state = S_EDIT;
                    w_entry = '0;
                    w_dc    = '0;
                    w_start = 1'b1;
                    w_secs  = EDIT_S;
                end
            end
            S_EDIT: begin
                if (i_ok && w_full) begin
                    // the timer already stopped if it expired this same cycle
                    w_pw    = r_entry;
                    w_state = S_WAIT;
                    w_abort = !i_timer_finished;
                    w_entry = '0;
                    w_dc    = '0;
                end else if (i_timer_finished) begin
                    w_state = S_WAIT;
                    w_entry = '0;
                    w_dc    = '0;
                end else if (i_ok) begin
                    w_err   = 1'b1;
                    w_entry = '0;
                    w_dc    = '0;
                end
            end
            default: begin
                if (i_admin_button) begin
                    w_state = S_WAIT;
                    w_fc    = '0;
                    w_entry = '0;
                    w_dc    = '0;
                end
            end
        endcase
    end

    assign o_state       = r_state;
    assign o_timer_start = r_start;
    assign o_timer_abort = r_abort;
    assign o_timer_secs  = r_secs;
    assign o_digit_count = r_dc;
    assign o_fail_count  = r_fc;
    assign o_err         = r_err;
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed and randomized checks of lock_controller against a queue-based model.
module tb_lock_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = '0;
    logic       ld = 1'b0, ok = 1'b0, adm = 1'b0, tf = 1'b0;
    logic [1:0] o_state, o_fail_count;
    logic       o_timer_start, o_timer_abort, o_err;
    logic [7:0] o_timer_secs;
    logic [2:0] o_digit_count;

    int tests = 0;
    int fails = 0;

    int m_state, m_fc, m_secs;
    bit m_start, m_abort, m_err;
    int m_q[$];
    int m_pw[4];

    lock_controller dut (
        .clk(clk), .rst_n(rst_n), .i_switches(sw), .i_load(ld), .i_ok(ok),
        .i_admin_button(adm), .i_timer_finished(tf), .o_state(o_state),
        .o_timer_start(o_timer_start), .o_timer_abort(o_timer_abort),
        .o_timer_secs(o_timer_secs), .o_digit_count(o_digit_count),
        .o_fail_count(o_fail_count), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_fc = 0; m_secs = 0;
        m_start = 0; m_abort = 0; m_err = 0;
        m_q.delete();
        m_pw = '{1, 2, 3, 4};
    endtask

    function automatic bit code_ok();
        if (m_q.size() != 4) return 0;
        for (int i = 0; i < 4; i++) if (m_q[i] != m_pw[i]) return 0;
        return 1;
    endfunction

    // State codes: 0 waiting, 1 editing, 2 unlocked, 3 alarming.
    task automatic model_step();
        bit good;
        m_start = 0; m_abort = 0; m_err = 0;
        if (m_state == 0) begin
            if (ok) begin
                good = code_ok();
                m_q.delete();
                if (good) begin
                    m_state = 2; m_fc = 0; m_start = 1; m_secs = 20;
                end else begin
                    m_err = 1; m_fc++;
                    if (m_fc == 3) m_state = 3;
                end
            end else if (ld && m_q.size() < 4) m_q.push_back(int'(sw));
        end else if (m_state == 2) begin
            if (tf) m_state = 0;
            else if (ok) begin m_state = 0; m_abort = 1; end
            else if (adm) begin m_state = 1; m_q.delete(); m_start = 1; m_secs = 10; end
        end else if (m_state == 1) begin
            if (ok && m_q.size() == 4) begin
                for (int i = 0; i < 4; i++) m_pw[i] = m_q[i];
                m_state = 0; m_abort = !tf; m_q.delete();
            end else if (tf) begin m_state = 0; m_q.delete(); end
            else if (ok) begin m_err = 1; m_q.delete(); end
            else if (ld && m_q.size() < 4) m_q.push_back(int'(sw));
        end else if (adm) begin
            m_state = 0; m_fc = 0; m_q.delete();
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("state", int'(o_state), m_state);
        chk("fail_count", int'(o_fail_count), m_fc);
        chk("digit_count", int'(o_digit_count), m_q.size());
        chk("timer_start", int'(o_timer_start), int'(m_start));
        chk("timer_abort", int'(o_timer_abort), int'(m_abort));
        chk("timer_secs", int'(o_timer_secs), m_secs);
        chk("err", int'(o_err), int'(m_err));
        chk("start_abort_excl", int'(o_timer_start & o_timer_abort), 0);
    end

    task automatic step(input logic [3:0] s, input bit l, input bit o, input bit a, input bit t);
        sw = s; ld = l; ok = o; adm = a; tf = t;
        @(posedge clk);
        #2;
        ld = 0; ok = 0; adm = 0; tf = 0;
    endtask

    task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        step(a, 1, 0, 0, 0); step(b, 1, 0, 0, 0); step(c, 1, 0, 0, 0); step(d, 1, 0, 0, 0);
    endtask

    initial begin
        #3;
        chk("rst_state", int'(o_state), 0);
        chk("rst_secs", int'(o_timer_secs), 0);
        chk("rst_start", int'(o_timer_start), 0);
        @(posedge clk);
        #2 rst_n = 1;
        enter(1, 2, 3, 4);
        chk("dc_full", int'(o_digit_count), 4);
        step(0, 0, 1, 0, 0);
        chk("unlock_state", int'(o_state), 2);
        chk("unlock_start", int'(o_timer_start), 1);
        chk("unlock_secs", int'(o_timer_secs), 20);
        chk("unlock_dc", int'(o_digit_count), 0);
        step(0, 0, 0, 0, 0);
        chk("start_one_cycle", int'(o_timer_start), 0);
        chk("secs_held", int'(o_timer_secs), 20);
        step(0, 0, 0, 0, 1);
        chk("expire_state", int'(o_state), 0);
        chk("expire_no_abort", int'(o_timer_abort), 0);
        enter(1, 2, 3, 4);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("leave_state", int'(o_state), 0);
        chk("leave_abort", int'(o_timer_abort), 1);
        for (int i = 1; i <= 3; i++) begin
            enter(1, 2, 3, 5);
            step(0, 0, 1, 0, 0);
            chk("wrong_err", int'(o_err), 1);
            chk("wrong_fc", int'(o_fail_count), i);
        end
        chk("alarm_state", int'(o_state), 3);
        enter(1, 2, 3, 4);
        step(0, 0, 1, 0, 1);
        chk("alarm_hold", int'(o_state), 3);
        chk("alarm_dc", int'(o_digit_count), 0);
        step(0, 0, 0, 1, 0);
        chk("alarm_clear_state", int'(o_state), 0);
        chk("alarm_clear_fc", int'(o_fail_count), 0);
        enter(1, 2, 3, 4);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("edit_state", int'(o_state), 1);
        chk("edit_secs", int'(o_timer_secs), 10);
        chk("edit_start", int'(o_timer_start), 1);
        enter(9, 8, 7, 6);
        step(0, 0, 1, 0, 0);
        chk("commit_state", int'(o_state), 0);
        chk("commit_abort", int'(o_timer_abort), 1);
        enter(1, 2, 3, 4);
        step(0, 0, 1, 0, 0);
        chk("old_pw_err", int'(o_err), 1);
        enter(9, 8, 7, 6);
        step(0, 0, 1, 0, 0);
        chk("new_pw_unlock", int'(o_state), 2);
        step(0, 0, 1, 0, 0);
        enter(1, 1, 1, 1);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(4'(i + 1), 1, 0, 0, 0);
        chk("dc_saturate", int'(o_digit_count), 4);
        rst_n = 0;
        #1;
        chk("arst_state", int'(o_state), 0);
        chk("arst_dc", int'(o_digit_count), 0);
        chk("arst_fc", int'(o_fail_count), 0);
        chk("arst_secs", int'(o_timer_secs), 0);
        @(posedge clk);
        #2 rst_n = 1;
        enter(1, 2, 3, 4);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(3, 1, 0, 0, 0);
        step(3, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("short_edit_err", int'(o_err), 1);
        chk("short_edit_state", int'(o_state), 1);
        step(0, 0, 0, 0, 1);
        chk("edit_expire_state", int'(o_state), 0);
        enter(1, 2, 3, 4);
        step(0, 0, 1, 0, 0);
        chk("pw_kept", int'(o_state), 2);
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 3) != 0) ? 4'(m_pw[m_q.size() % 4]) : 4'($urandom_range(0, 15));
            step(s, $urandom_range(0, 9) < 4, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
